mont_exp_stream_io: RTL and testbench

//  Word-serial front/back end for mont_exp. Collects operands x then y as WORD-bit

---
 rtl/mont_exp_stream_io.sv | 139 +++++++++++++
 tb/tb_mont_exp_stream_io.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_exp_stream_io.sv
// Word-serial operand loader / result drainer around mont_exp (x then y in, z out).
// Optional watchdog on the RUN state: define MONT_IO_TIMEOUT_EN to enable it.
module mont_exp_stream_io #(
    parameter int WIDTH   = 192,
    parameter int WORD    = 32,
    parameter int TMO_CYC = 200000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WORD-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WORD-1:0]  out_data,
    output logic             out_last,
    output logic             busy,
    output logic             err,
    output logic [WIDTH-1:0] exp_x,
    output logic [WIDTH-1:0] exp_y,
    output logic             exp_start,
    input  logic [WIDTH-1:0] exp_z,
    input  logic             exp_done
);
    localparam int NWORDS = WIDTH / WORD;
    localparam logic [2:0] LAST_IDX = 3'(NWORDS - 1);

    typedef enum logic [1:0] {S_LOAD_X, S_LOAD_Y, S_RUN, S_SEND} state_t;

    state_t                       r_state, w_state_next;
    logic [2:0]                   r_cnt, w_cnt_next;
    logic [NWORDS-1:0][WORD-1:0]  r_x, w_x_next;
    logic [NWORDS-1:0][WORD-1:0]  r_y, w_y_next;
    logic [NWORDS-1:0][WORD-1:0]  r_z, w_z_next;
    logic                         w_tmo;

`ifdef MONT_IO_TIMEOUT_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_err;

    // Counts completed RUN cycles; fires on the TMO_CYC-th one unless done arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= (r_state == S_RUN) ? r_tmo_cnt + 1'b1 : '0;
            r_err     <= r_err | w_tmo;
        end
    end

    assign w_tmo = (r_state == S_RUN) && !exp_done && (r_tmo_cnt == TW'(TMO_CYC - 1));
    assign err   = r_err;
`else
    assign w_tmo = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD_X;
            r_cnt   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_x     <= w_x_next;
            r_y     <= w_y_next;
            r_z     <= w_z_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_x_next     = r_x;
        w_y_next     = r_y;
        w_z_next     = r_z;
        case (r_state)
            S_LOAD_X: begin
                if (in_valid) begin
                    w_x_next[r_cnt] = in_data;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = S_LOAD_Y;
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end
            S_LOAD_Y: begin
                if (in_valid) begin
                    w_y_next[r_cnt] = in_data;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = S_RUN;
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end
            S_RUN: begin
                // Done takes priority over a watchdog expiry in the same cycle.
                if (exp_done) begin
                    w_z_next     = exp_z;
                    w_state_next = S_SEND;
                end else if (w_tmo) begin
                    w_z_next     = '1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_next   = '0;
                        w_state_next = S_LOAD_X;
                    end else begin
                        w_cnt_next = r_cnt + 3'd1;
                    end
                end
            end
            default: w_state_next = S_LOAD_X;
        endcase
    end

    // All outputs decode registered state, so exp_start/out_valid are glitch-free.
    assign in_ready  = (r_state == S_LOAD_X) || (r_state == S_LOAD_Y);
    assign exp_start = (r_state == S_RUN);
    assign out_valid = (r_state == S_SEND);
    assign out_last  = (r_state == S_SEND) && (r_cnt == LAST_IDX);
    assign out_data  = r_z[r_cnt];
    assign busy      = !((r_state == S_LOAD_X) && (r_cnt == 3'd0));
    assign exp_x     = r_x;
    assign exp_y     = r_y;

endmodule

// File: tb/tb_mont_exp_stream_io.sv
// Directed bench for mont_exp_stream_io with a mont_exp stub (done 20 cycles after
// start, z = x ^ y). The watchdog scenario runs only when MONT_IO_TIMEOUT_EN is defined.
module tb_mont_exp_stream_io;
    localparam int WIDTH = 192;
    localparam int WORD  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WORD-1:0]  in_data = '0;
    logic             out_ready = 1'b0;
    logic             in_ready, out_valid, out_last, busy, err, exp_start, exp_done;
    logic [WORD-1:0]  out_data;
    logic [WIDTH-1:0] exp_x, exp_y, exp_z;

    logic stub_en    = 1'b1;
    logic extra_done = 1'b0;
    logic stub_done;
    int   stub_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mont_exp_stream_io #(.WIDTH(WIDTH), .WORD(WORD), .TMO_CYC(50)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .err(err),
        .exp_x(exp_x), .exp_y(exp_y), .exp_start(exp_start),
        .exp_z(exp_z), .exp_done(exp_done)
    );

    // mont_exp stub
    always @(posedge clk) begin
        if (rst || !exp_start) begin
            stub_cnt  <= 0;
            stub_done <= 1'b0;
        end else begin
            stub_cnt  <= stub_cnt + 1;
            stub_done <= stub_en && (stub_cnt == 19);
        end
    end
    assign exp_z    = exp_x ^ exp_y;
    assign exp_done = stub_done | extra_done;

    localparam logic [191:0] X11 = 192'd11;
    localparam logic [191:0] Y2  = 192'd2;
    localparam logic [191:0] Z9  = 192'd9;

    // Offers the first n of the 12 operand words; returns at the negedge before the
    // edge that accepts word n.
    task automatic load_ops(input logic [191:0] x, input logic [191:0] y,
                            input bit gappy, input int n, output bit ok);
        logic [31:0] w[12];
        int i = 0;
        int guard = 0;
        for (int j = 0; j < 6; j++) begin
            w[j]     = x[j*32 +: 32];
            w[j + 6] = y[j*32 +: 32];
        end
        while (i < n && guard < 200) begin
            @(negedge clk);
            guard++;
            if (gappy && (guard % 2 == 0)) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = w[i];
                if (in_ready) i++;
            end
        end
        ok = (i == n);
    endtask

    // Drains six result words, optionally holding out_ready low for stall_len cycles
    // when word stall_at is on offer.
    task automatic collect(input int stall_at, input int stall_len,
                           output logic [191:0] res, output logic [5:0] lasts,
                           output bit stall_ok, output bit done_ok);
        int k = 0;
        int cyc = 0;
        int left = stall_len;
        logic [31:0] held = '0;
        bit holding = 1'b0;
        res = '0;
        lasts = '0;
        stall_ok = 1'b1;
        while (k < 6 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (k == stall_at && left > 0 && out_valid) begin
                out_ready = 1'b0;
                left--;
                if (!holding) begin
                    held = out_data;
                    holding = 1'b1;
                end else if (out_data !== held) begin
                    stall_ok = 1'b0;
                end
            end else begin
                out_ready = 1'b1;
                if (holding && (out_data !== held || !out_valid)) stall_ok = 1'b0;
                holding = 1'b0;
                if (out_valid) begin
                    res[k*32 +: 32] = out_data;
                    lasts[k] = out_last;
                    k++;
                end
            end
        end
        done_ok = (k == 6);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
        n_total++; if ({out_valid, out_last, exp_start, busy, err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {out_valid, out_last, exp_start, busy, err}); else n_pass++;
        n_total++; if ({exp_x, exp_y, out_data} !== '0)
            $display("FAIL reset_data: got x=%h y=%h d=%h want 0", exp_x, exp_y, out_data); else n_pass++;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        load_ops(X11, Y2, 1'b0, 12, ok);
        n_total++; if (ok !== 1'b1) $display("FAIL basic_load: got %b want 1", ok); else n_pass++;
        n_total++; if (exp_start !== 1'b0) $display("FAIL basic_start_pre: got %b want 0", exp_start); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (exp_start !== 1'b1) $display("FAIL basic_start: got %b want 1", exp_start); else n_pass++;
        n_total++; if (exp_x !== X11 || exp_y !== Y2)
            $display("FAIL basic_ops: got x=%h y=%h want x=%h y=%h", exp_x, exp_y, X11, Y2); else n_pass++;
        n_total++; if (in_ready !== 1'b0 || busy !== 1'b1)
            $display("FAIL basic_run_flags: got rdy=%b busy=%b want 0 1", in_ready, busy); else n_pass++;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (dn_ok !== 1'b1) $display("FAIL basic_drain: got %b want 1", dn_ok); else n_pass++;
        n_total++; if (res !== Z9) $display("FAIL basic_result: got %h want %h", res, Z9); else n_pass++;
        n_total++; if (lasts !== 6'b100000) $display("FAIL basic_last: got %b want 100000", lasts); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        n_total++; if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL basic_idle: got v/rdy/busy=%b want 010", {out_valid, in_ready, busy}); else n_pass++;
        $display("test_basic result=%h", res);
    endtask

    task automatic test_backpressure();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        load_ops(X11, Y2, 1'b1, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (ok !== 1'b1 || exp_x !== X11 || exp_y !== Y2)
            $display("FAIL bp_load: got ok=%b x=%h y=%h want 1 %h %h", ok, exp_x, exp_y, X11, Y2); else n_pass++;
        collect(2, 3, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== Z9 || dn_ok !== 1'b1)
            $display("FAIL bp_result: got %h done=%b want %h 1", res, dn_ok, Z9); else n_pass++;
        n_total++; if (st_ok !== 1'b1) $display("FAIL bp_stall_hold: got %b want 1", st_ok); else n_pass++;
        n_total++; if (lasts !== 6'b100000) $display("FAIL bp_last: got %b want 100000", lasts); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_backpressure result=%h", res);
    endtask

    task automatic test_hold_valid();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        logic [191:0] x = 192'h00000006_00000005_00000004_00000003_00000002_00000001;
        logic [191:0] y = 192'h0000FFFF_00000000_00000000_00000000_00000000_F0F0F0F0;
        logic [191:0] z = 192'h0000FFF9_00000005_00000004_00000003_00000002_F0F0F0F1;
        load_ops(x, y, 1'b0, 12, ok);
        @(negedge clk);
        in_data = 32'hBAD0BAD0;
        n_total++; if (in_ready !== 1'b0) $display("FAIL hold_in_ready: got %b want 0", in_ready); else n_pass++;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== z || dn_ok !== 1'b1)
            $display("FAIL hold_result: got %h done=%b want %h 1", res, dn_ok, z); else n_pass++;
        n_total++; if (exp_x !== x || exp_y !== y)
            $display("FAIL hold_ops_stable: got x=%h y=%h want x=%h y=%h", exp_x, exp_y, x, y); else n_pass++;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        load_ops(X11, Y2, 1'b0, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== Z9 || dn_ok !== 1'b1)
            $display("FAIL hold_next_result: got %h done=%b want %h 1", res, dn_ok, Z9); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_hold_valid result=%h", res);
    endtask

    task automatic test_reset_mid();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        load_ops(X11, Y2, 1'b0, 4, ok);
        @(negedge clk);
        in_valid = 1'b0;
        n_total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_pre: got %b want 1", busy); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if ({busy, in_ready} !== 2'b01 || exp_x !== '0)
            $display("FAIL rstmid_partial: got busy=%b rdy=%b x=%h want 0 1 0", busy, in_ready, exp_x); else n_pass++;
        load_ops(X11, Y2, 1'b0, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (exp_start !== 1'b1) $display("FAIL rstmid_run_start: got %b want 1", exp_start); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (exp_start !== 1'b0 || exp_y !== '0 || out_valid !== 1'b0)
            $display("FAIL rstmid_run: got start=%b y=%h v=%b want 0 0 0", exp_start, exp_y, out_valid); else n_pass++;
        load_ops(X11, Y2, 1'b0, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== Z9 || dn_ok !== 1'b1)
            $display("FAIL rstmid_result: got %h done=%b want %h 1", res, dn_ok, Z9); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_reset_mid result=%h", res);
    endtask

    task automatic test_same_edge_done();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        logic [191:0] y = 192'h00000001_00000000_00000000_00000000_00000000_00000002;
        logic [191:0] z = 192'h00000001_00000000_00000000_00000000_00000000_00000009;
        load_ops(X11, y, 1'b0, 12, ok);
        extra_done = 1'b1;
        @(negedge clk);
        extra_done = 1'b0;
        in_valid = 1'b0;
        n_total++; if (out_valid !== 1'b0 || exp_start !== 1'b1)
            $display("FAIL early_done_ignored: got v=%b start=%b want 0 1", out_valid, exp_start); else n_pass++;
        @(negedge clk);
        n_total++; if (out_valid !== 1'b0) $display("FAIL early_done_late: got %b want 0", out_valid); else n_pass++;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== z || dn_ok !== 1'b1)
            $display("FAIL early_done_result: got %h done=%b want %h 1", res, dn_ok, z); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        $display("test_same_edge_done result=%h", res);
    endtask

`ifdef MONT_IO_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, st_ok, dn_ok;
        logic [191:0] res;
        logic [5:0] lasts;
        stub_en = 1'b0;
        load_ops(X11, Y2, 1'b0, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (49) @(negedge clk);
        n_total++; if (err !== 1'b0 || out_valid !== 1'b0)
            $display("FAIL tmo_before: got err=%b v=%b want 0 0", err, out_valid); else n_pass++;
        @(negedge clk);
        n_total++; if ({err, out_valid, exp_start} !== 3'b110)
            $display("FAIL tmo_fire: got err/v/start=%b want 110", {err, out_valid, exp_start}); else n_pass++;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== {192{1'b1}} || dn_ok !== 1'b1)
            $display("FAIL tmo_result: got %h done=%b want all ones", res, dn_ok); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        stub_en = 1'b1;
        load_ops(X11, Y2, 1'b0, 12, ok);
        @(negedge clk);
        in_valid = 1'b0;
        collect(-1, 0, res, lasts, st_ok, dn_ok);
        n_total++; if (res !== Z9 || err !== 1'b1)
            $display("FAIL tmo_sticky: got res=%h err=%b want %h 1", res, err, Z9); else n_pass++;
        @(negedge clk);
        out_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (err !== 1'b0) $display("FAIL tmo_clear: got %b want 0", err); else n_pass++;
        $display("test_timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_hold_valid();
        test_reset_mid();
        test_same_edge_done();
`ifdef MONT_IO_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
